shift_register_var: RTL and testbench

Runtime-configurable, flushable delay line. Successor to the fixed-depth shift register used in the CIC decimator commutator path. Depth is selectable at run time from 1 to `gp_max_stages` without resynthesis. The block adds a flush command, a fill state machine, a per-sample valid strobe and a full tap bus for FIR/polyphase consumers. It sits between the rate-change stages and the commutator/FIR data paths.

---
 rtl/dsp_delay_pkg.sv | 36 +++
 rtl/dline_stage.sv | 29 ++
 rtl/shift_register_var.sv | 154 +++++++++++++++
 tb/tb_shift_register_var.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_delay_pkg.sv
// Shared definitions for the runtime-configurable delay line: fill-state
// encoding, counter width helper and the depth clamp.
package dsp_delay_pkg;

    // Fill state of the delay line.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } fill_state_t;

    // Depth used when the block is built with its default parameters.
    localparam int unsigned DEFAULT_MAX_STAGES = 16;

    // Width needed to hold a depth or fill count in 0..max_stages.
    function automatic int unsigned cnt_width(input int unsigned max_stages);
        return $clog2(max_stages + 1);
    endfunction

    // Counter / length width for the default build.
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_MAX_STAGES + 1);

    // Requested depth forced into 1..max_len; 0 becomes 1, anything above
    // the physical depth becomes the physical depth.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/dline_stage.sv
// One sample register of the delay line. Reset and flush both clear it;
// reset wins, then flush, then the shift enable.
module dline_stage #(
    parameter int gp_data_width = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_ena,
    input  logic [gp_data_width-1:0] i_d,
    output logic [gp_data_width-1:0] o_q
);

    logic [gp_data_width-1:0] data_q;

    // Sample register: clear on reset/flush, capture on enable, else hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
        end else if (i_flush) begin
            data_q <= '0;
        end else if (i_ena) begin
            data_q <= i_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/shift_register_var.sv
// Runtime-configurable, flushable delay line. All physical stages shift on
// every enable; the active depth only selects which stage drives o_data and
// how many shifts the fill counter must see before the line counts as full.
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where i_ena is high and neither reset nor flush is asserted. o_valid
// is a one-cycle strobe on the cycle after such an edge whenever the line is
// full after it; the consumer must take o_data in that cycle.
module shift_register_var
    import dsp_delay_pkg::*;
#(
    parameter int gp_data_width = 8,
    parameter int gp_max_stages = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_ena,
    input  logic                                   i_flush,
    input  logic                                   i_load,
    input  logic [cnt_width(gp_max_stages)-1:0]    i_len,
    input  logic [gp_data_width-1:0]               i_data,
    output logic [gp_data_width-1:0]               o_data,
    output logic [gp_max_stages*gp_data_width-1:0] o_taps,
    output logic                                   o_valid,
    output logic                                   o_fill_done,
    output logic [cnt_width(gp_max_stages)-1:0]    o_len,
    output logic [1:0]                             o_dbg_state
);

    localparam int LEN_W = cnt_width(gp_max_stages);
    localparam int W     = gp_data_width;

    logic [W-1:0]     stage_q [gp_max_stages];
    logic [W-1:0]     stage_d [gp_max_stages];
    logic             shift_en;

    fill_state_t      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] load_len;

    // A flush cycle discards the input sample and does not shift.
    assign shift_en = i_ena && !i_flush;

    // Chain wiring: stage 0 takes the new sample, stage k takes stage k-1.
    always_comb begin
        for (int k = 0; k < gp_max_stages; k++) begin
            stage_d[k] = (k == 0) ? i_data : stage_q[(k == 0) ? 0 : k-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < gp_max_stages; g++) begin : g_stage
            dline_stage #(
                .gp_data_width(W)
            ) u_stage (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_flush(i_flush),
                .i_ena  (shift_en),
                .i_d    (stage_d[g]),
                .o_q    (stage_q[g])
            );
        end
    endgenerate

    // Depth requested by i_len after clamping into 1..gp_max_stages.
    assign load_len = LEN_W'(clamp_len(int'(i_len), gp_max_stages));

    // Fill count after one more accepted sample, saturating at the depth.
    assign cnt_inc = (cnt_q < len_q) ? (cnt_q + LEN_W'(1)) : cnt_q;

    // Next-state logic for depth, fill counter, fill state and valid strobe.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;

        if (i_load) begin
            len_d = load_len;
        end

        if (i_flush) begin
            cnt_d   = '0;
            state_d = ST_EMPTY;
        end else if (i_load) begin
            if (i_ena) begin
                cnt_d   = LEN_W'(1);
                state_d = (load_len == LEN_W'(1)) ? ST_FULL : ST_FILLING;
                valid_d = (load_len == LEN_W'(1));
            end else begin
                cnt_d   = '0;
                state_d = ST_EMPTY;
            end
        end else if (i_ena) begin
            cnt_d = cnt_inc;
            case (state_q)
                ST_EMPTY, ST_FILLING: begin
                    state_d = (cnt_inc == len_q) ? ST_FULL : ST_FILLING;
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
            valid_d = (state_d == ST_FULL);
        end
    end

    // Control registers; reset restores an empty line at maximum depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            len_q   <= LEN_W'(gp_max_stages);
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Output tap: the stage at index r_len-1.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < gp_max_stages; k++) begin
            if (LEN_W'(k + 1) == len_q) begin
                o_data = stage_q[k];
            end
        end
    end

    // Flatten all stages onto the tap bus, stage 0 in the low bits.
    always_comb begin
        o_taps = '0;
        for (int k = 0; k < gp_max_stages; k++) begin
            o_taps[k*W +: W] = stage_q[k];
        end
    end

    assign o_valid     = valid_q;
    assign o_fill_done = (state_q == ST_FULL);
    assign o_len       = len_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_shift_register_var.sv
// Directed bench for shift_register_var with default parameters (8-bit, 16 stages).
module tb_shift_register_var;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int LW = 5;

  logic           i_clk;
  logic           i_rst;
  logic           i_ena;
  logic           i_flush;
  logic           i_load;
  logic [LW-1:0]  i_len;
  logic [W-1:0]   i_data;
  logic [W-1:0]   o_data;
  logic [N*W-1:0] o_taps;
  logic           o_valid;
  logic           o_fill_done;
  logic [LW-1:0]  o_len;
  logic [1:0]     o_dbg_state;

  int n_cmp;
  int n_bad;

  logic [N*W-1:0] exp_taps;

  shift_register_var #(
    .gp_data_width(W),
    .gp_max_stages(N)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ena      (i_ena),
    .i_flush    (i_flush),
    .i_load     (i_load),
    .i_len      (i_len),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_taps     (o_taps),
    .o_valid    (o_valid),
    .o_fill_done(o_fill_done),
    .o_len      (o_len),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // checker
  task automatic check_eq(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one clock edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ena, input logic flush,
                       input logic load, input logic [LW-1:0] len, input logic [W-1:0] data);
    i_rst   = rst;
    i_ena   = ena;
    i_flush = flush;
    i_load  = load;
    i_len   = len;
    i_data  = data;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rst = 1'b1; i_ena = 1'b0; i_flush = 1'b0; i_load = 1'b0; i_len = '0; i_data = '0;

    // reset values
    drive(1, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    check_eq("rst_data", o_data, 0);
    check_eq("rst_taps", o_taps, 0);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_fill", o_fill_done, 0);
    check_eq("rst_len", o_len, 16);
    check_eq("rst_state", o_dbg_state, 0);

    // ramp 1..16 at full depth
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 0, 0, 0, W'(i));
      check_eq($sformatf("ramp_valid_%0d", i), o_valid, (i == 16) ? 1 : 0);
      check_eq($sformatf("ramp_fill_%0d", i), o_fill_done, (i == 16) ? 1 : 0);
    end
    check_eq("ramp_data", o_data, 1);
    exp_taps = '0;
    for (int k = 0; k < N; k++) exp_taps[k*W +: W] = W'(16 - k);
    check_eq("ramp_taps", o_taps, exp_taps);
    drive(0, 1, 0, 0, 0, 8'd17);
    check_eq("stream_data", o_data, 2);
    check_eq("stream_valid", o_valid, 1);
    drive(0, 0, 0, 0, 0, 8'd99);
    check_eq("idle_valid", o_valid, 0);
    check_eq("idle_data", o_data, 2);

    // load depth 4 while full, no enable
    drive(0, 0, 0, 1, 5'd4, 8'd0);
    check_eq("ld4_len", o_len, 4);
    check_eq("ld4_valid", o_valid, 0);
    check_eq("ld4_fill", o_fill_done, 0);
    check_eq("ld4_state", o_dbg_state, 0);
    check_eq("ld4_data", o_data, 14);
    for (int i = 18; i <= 21; i++) begin
      drive(0, 1, 0, 0, 0, W'(i));
      check_eq($sformatf("ld4_valid_%0d", i), o_valid, (i == 21) ? 1 : 0);
    end
    check_eq("ld4_out", o_data, 18);

    // clamp: 0 -> 1, then depth 1 streaming
    drive(0, 0, 0, 1, 5'd0, 8'd0);
    check_eq("ld0_len", o_len, 1);
    drive(0, 1, 0, 0, 0, 8'd22);
    check_eq("len1_valid", o_valid, 1);
    check_eq("len1_data", o_data, 22);
    check_eq("len1_fill", o_fill_done, 1);
    drive(0, 0, 0, 0, 0, 8'd23);
    check_eq("len1_idle_valid", o_valid, 0);
    check_eq("len1_idle_data", o_data, 22);
    drive(0, 1, 0, 0, 0, 8'd24);
    check_eq("len1_valid2", o_valid, 1);
    check_eq("len1_data2", o_data, 24);

    // clamp: 31 -> 16
    drive(0, 0, 0, 1, 5'd31, 8'd0);
    check_eq("ld31_len", o_len, 16);

    // depth 3 with toggling enable
    drive(0, 0, 0, 1, 5'd3, 8'd0);
    drive(0, 1, 0, 0, 0, 8'h31);
    check_eq("tog_v1", o_valid, 0);
    check_eq("tog_st1", o_dbg_state, 1);
    drive(0, 0, 0, 0, 0, 8'hEE);
    check_eq("tog_v2", o_valid, 0);
    drive(0, 1, 0, 0, 0, 8'h32);
    check_eq("tog_v3", o_valid, 0);
    drive(0, 0, 0, 0, 0, 8'hEE);
    check_eq("tog_v4", o_valid, 0);
    drive(0, 1, 0, 0, 0, 8'h33);
    check_eq("tog_v5", o_valid, 1);
    check_eq("tog_fill5", o_fill_done, 1);
    check_eq("tog_data5", o_data, 8'h31);
    drive(0, 0, 0, 0, 0, 8'hEE);
    check_eq("tog_v6", o_valid, 0);
    check_eq("tog_fill6", o_fill_done, 1);

    // flush with enable and data 0x55
    drive(0, 1, 1, 0, 0, 8'h55);
    check_eq("fl_taps", o_taps, 0);
    check_eq("fl_state", o_dbg_state, 0);
    check_eq("fl_valid", o_valid, 0);
    check_eq("fl_fill", o_fill_done, 0);
    check_eq("fl_len", o_len, 3);
    drive(0, 1, 0, 0, 0, 8'h01);
    check_eq("fl_after_taps", o_taps, 128'h01);

    // load with enable into depth 1: immediate full
    drive(0, 1, 0, 1, 5'd1, 8'h77);
    check_eq("ldena_len", o_len, 1);
    check_eq("ldena_valid", o_valid, 1);
    check_eq("ldena_data", o_data, 8'h77);
    check_eq("ldena_fill", o_fill_done, 1);

    // flush together with load still loads depth
    drive(0, 1, 1, 1, 5'd2, 8'h66);
    check_eq("flld_len", o_len, 2);
    check_eq("flld_taps", o_taps, 0);
    check_eq("flld_valid", o_valid, 0);

    // restore depth 16, fill 5, then reset mid-fill
    drive(0, 0, 0, 1, 5'd16, 8'h00);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, W'(8'hA0 + i));
    check_eq("mid_state", o_dbg_state, 1);
    drive(1, 1, 0, 0, 0, 8'hEE);
    check_eq("mrst_taps", o_taps, 0);
    check_eq("mrst_data", o_data, 0);
    check_eq("mrst_state", o_dbg_state, 0);
    check_eq("mrst_valid", o_valid, 0);
    check_eq("mrst_len", o_len, 16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0, 0, W'(8'h40 + i));
      check_eq($sformatf("refill_valid_%0d", i), o_valid, (i == 15) ? 1 : 0);
    end
    check_eq("refill_data", o_data, 8'h40);
    drive(0, 0, 0, 0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
